tdm_demux1_to_8: RTL and testbench
==================================

Name: tdm_demux1_to_8

Overview:
- Receive end of the 8-channel select path: one serial bit stream carries channels 0..7 in time-division slots, one bit per slot.
- A frame sync marks slot 0. The block locks to the sync, deserializes each 8-slot frame into an 8-bit shadow register, and commits the whole frame to the parallel outputs atomically.
- It sits after the serial link and feeds per-channel logic that expects i0..i7-style bits.

Parameters:
- RESET_VAL, 8'h00, value driven on out[7:0] during and after reset until the first committed frame.
- SYNC_EVERY_FRAME, 1, 1 = sync must accompany every slot-0 bit while locked; 0 = flywheel (sync checked only when present).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit for the current slot.
- din_valid  input  1  din/sync qualify; a bit is consumed only on cycles with din_valid=1.
- sync  input  1  asserted together with the slot-0 bit; ignored when din_valid=0.
- out  output  8  committed frame; out[k] = bit from slot k.
- frame_valid  output  1  one-cycle pulse when out updates.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a sync violation.
- slot  output  3  next slot index expected (debug).

Behaviour:
- Reset (asynchronous, active-high): state=HUNT, slot=0, shadow=0, out=RESET_VAL, frame_valid=0, sync_err=0, locked=0. Reset mid-frame discards the partial frame. out keeps RESET_VAL, not the partial data.
- All outputs are registered. Cycles with din_valid=0 change nothing except clearing the frame_valid/sync_err pulses.
- HUNT state:
  - Valid bits without sync are discarded.
  - Valid bit with sync=1: shadow[0]<=din, slot<=1, state<=LOCKED, locked<=1 on the same edge.
- LOCKED state, valid bit at slot s:
  - Case s=1..6, sync=0: shadow[s]<=din, slot<=s+1.
  - Case s=7, sync=0: out<={din, shadow[6:0]}, frame_valid<=1 (out and frame_valid visible the cycle after the slot-7 edge), slot<=0.
    - Latency is 1 cycle from the slot-7 sample to out.
    - Back-to-back frames with din_valid held high give one frame_valid pulse every 8 cycles.
  - Case s=0, sync=1: shadow[0]<=din, slot<=1 (normal frame start).
  - Case s=0, sync=0, SYNC_EVERY_FRAME=1: sync_err<=1, state<=HUNT, locked<=0, slot<=0, bit discarded.
  - Case s=0, sync=0, SYNC_EVERY_FRAME=0: treat as a normal slot-0 bit (flywheel).
  - Case s!=0, sync=1 (early/misplaced sync): sync_err<=1, partial frame discarded (no commit, out unchanged), realign with this bit as slot 0: shadow[0]<=din, slot<=1, stay LOCKED.
- Shadow bits not yet written in a frame are never exposed, because commit happens only at slot 7.
- frame_valid and sync_err are never asserted together, since slot 7 with sync=1 is a misplaced sync and does not commit.

Test Plan:
- Reset check:
  - Stimulus: reset=1 for 3 cycles with din/valid toggling, then release.
  - Required: out=8'h00, frame_valid=0, locked=0, sync_err=0, slot=0 throughout.
- Lock and one frame:
  - Stimulus: two valid bits with no sync, then sync+din=1 on slot 0, then slots 1..7 = 0,1,1,0,0,1,0 with valid held high.
  - Required: locked rises on the sync edge; one cycle after the slot-7 edge out=8'h4D, frame_valid is a single-cycle pulse.
- Gapped input:
  - Stimulus: same frame with din_valid=0 inserted after slots 2 and 5.
  - Required: identical out=8'h4D; frame_valid arrives 2 cycles later than in the previous test; no sync_err.
- Misplaced sync:
  - Stimulus: locked; slots 0..3 sent, then sync=1 at slot 4 carrying a new frame 8'hFF.
  - Required: sync_err pulses once, no commit for the partial frame, locked stays 1, then out=8'hFF with frame_valid.
- Missing sync, SYNC_EVERY_FRAME=1:
  - Stimulus: after a good frame, a slot-0 bit arrives without sync.
  - Required: sync_err pulse, locked=0, out keeps its previous value; the next sync relocks.
  - Rerun with SYNC_EVERY_FRAME=0: no error and the frame commits normally.
- Async reset mid-frame:
  - Stimulus: reset asserted between clock edges at slot 5.
  - Required: locked=0 and out=RESET_VAL immediately, without waiting for a clock edge; no frame_valid afterwards until a fresh sync and 8 slots.

Source files
------------

// File: rtl/tdm_demux1_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux1_to_8
//  Description : Receive side of an 8-slot TDM select link. Locks to a frame
//                sync that marks slot 0, deserializes one bit per valid slot
//                into a shadow register and commits each complete frame to the
//                parallel output in a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux1_to_8 #(
  parameter logic [7:0] RESET_VAL        = 8'h00,
  parameter bit         SYNC_EVERY_FRAME = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] out,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err,
  output logic [2:0] slot
);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [2:0] c_slot_first = 3'd0;
  localparam logic [2:0] c_slot_last  = 3'd7;

  state_t     r_state;
  logic [2:0] r_slot;
  // Slot 7 never lands in the shadow: it goes straight to the output on commit.
  logic [6:0] r_shadow;
  logic [7:0] r_out;
  logic       r_frame_valid;
  logic       r_locked;
  logic       r_sync_err;

  // Frame-lock state machine, shadow capture and atomic frame commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_slot        <= c_slot_first;
      r_shadow      <= '0;
      r_out         <= RESET_VAL;
      r_frame_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle whether or not a bit is consumed.
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (din_valid) begin
        case (r_state)
          ST_HUNT: begin
            // Only a sync-qualified bit can start a frame; everything else is noise.
            if (sync) begin
              r_shadow[0] <= din;
              r_slot      <= 3'd1;
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (sync && (r_slot != c_slot_first)) begin
              // Sync arrived early: drop the partial frame and restart on this bit.
              r_sync_err  <= 1'b1;
              r_shadow[0] <= din;
              r_slot      <= 3'd1;
            end else if (r_slot == c_slot_first) begin
              if (sync || !SYNC_EVERY_FRAME) begin
                r_shadow[0] <= din;
                r_slot      <= 3'd1;
              end else begin
                // Expected sync missing: give up lock and discard the bit.
                r_sync_err <= 1'b1;
                r_state    <= ST_HUNT;
                r_locked   <= 1'b0;
                r_slot     <= c_slot_first;
              end
            end else if (r_slot == c_slot_last) begin
              r_out         <= {din, r_shadow};
              r_frame_valid <= 1'b1;
              r_slot        <= c_slot_first;
            end else begin
              r_shadow[r_slot] <= din;
              r_slot           <= r_slot + 3'd1;
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
            r_slot   <= c_slot_first;
          end
        endcase
      end
    end
  end

  assign out         = r_out;
  assign frame_valid = r_frame_valid;
  assign locked      = r_locked;
  assign sync_err    = r_sync_err;
  assign slot        = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux1_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux1_to_8
//  Description : Self-checking bench for tdm_demux1_to_8. Drives a strict-sync
//                and a flywheel instance from the same stimulus and compares
//                both against a frame-level reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux1_to_8;

  localparam logic [7:0] RESET_VAL = 8'h00;

  logic clk = 1'b0;
  logic reset, din, din_valid, sync;

  logic [1:0][7:0] dout;
  logic [1:0]      dfv, dlk, derr;
  logic [1:0][2:0] dslot;

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = strict sync, index 1 = flywheel.
  bit   [1:0]      m_lk, m_fv, m_err;
  logic [1:0][7:0] m_out;
  logic [1:0][7:0] m_sh;
  int              m_cnt [2];

  tdm_demux1_to_8 #(.RESET_VAL(RESET_VAL), .SYNC_EVERY_FRAME(1'b1)) u_strict (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .out(dout[0]), .frame_valid(dfv[0]), .locked(dlk[0]), .sync_err(derr[0]),
    .slot(dslot[0])
  );

  tdm_demux1_to_8 #(.RESET_VAL(RESET_VAL), .SYNC_EVERY_FRAME(1'b0)) u_fly (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .out(dout[1]), .frame_valid(dfv[1]), .locked(dlk[1]), .sync_err(derr[1]),
    .slot(dslot[1])
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lk[m] = 0; m_fv[m] = 0; m_err[m] = 0;
      m_out[m] = RESET_VAL; m_sh[m] = '0; m_cnt[m] = 0;
    end
  endtask

  // One consumed bit: frames are collected bit by bit and emitted once 8 are held.
  task automatic model_step(input logic d, input logic s);
    for (int m = 0; m < 2; m++) begin
      m_fv[m] = 0; m_err[m] = 0;
      if (!m_lk[m]) begin
        if (s) begin
          m_lk[m] = 1; m_sh[m] = '0; m_sh[m][0] = d; m_cnt[m] = 1;
        end
      end else if (s && m_cnt[m] != 0) begin
        m_err[m] = 1; m_sh[m] = '0; m_sh[m][0] = d; m_cnt[m] = 1;
      end else if (m_cnt[m] == 0 && !s && m == 0) begin
        m_err[m] = 1; m_lk[m] = 0;
      end else begin
        m_sh[m][m_cnt[m]] = d;
        m_cnt[m] = m_cnt[m] + 1;
        if (m_cnt[m] == 8) begin
          m_out[m] = m_sh[m]; m_fv[m] = 1; m_cnt[m] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      cmp($sformatf("out[%0d]", m), 32'(dout[m]), 32'(m_out[m]));
      cmp($sformatf("frame_valid[%0d]", m), 32'(dfv[m]), 32'(m_fv[m]));
      cmp($sformatf("locked[%0d]", m), 32'(dlk[m]), 32'(m_lk[m]));
      cmp($sformatf("sync_err[%0d]", m), 32'(derr[m]), 32'(m_err[m]));
      cmp($sformatf("slot[%0d]", m), 32'(dslot[m]), m_lk[m] ? 32'(m_cnt[m]) : 32'd0);
    end
  endtask

  task automatic tick(input logic d, input logic v, input logic s);
    din = d; din_valid = v; sync = s;
    @(posedge clk);
    if (reset) model_reset();
    else if (v) model_step(d, s);
    else begin m_fv = '0; m_err = '0; end
    #1 check_all();
  endtask

  // Sends one frame; gap_mask bit k inserts an idle cycle after slot k.
  task automatic send_frame(input logic [7:0] v, input logic with_sync, input logic [7:0] gap_mask);
    for (int k = 0; k < 8; k++) begin
      tick(v[k], 1'b1, (k == 0) ? with_sync : 1'b0);
      if (gap_mask[k]) tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    model_reset();
    #1 check_all();

    // Reset held with toggling inputs.
    for (int i = 0; i < 3; i++) tick(1'(i), 1'b1, 1'(i == 1));
    reset = 1'b0;

    // Lock and one frame: noise, then 8'h4D.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    send_frame(8'h4D, 1'b1, 8'h00);
    cmp("lock_out_4d", 32'(dout[0]), 32'h4D);
    cmp("lock_fv", 32'(dfv[0]), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    cmp("lock_fv_pulse", 32'(dfv[0]), 32'd0);

    // Gapped input: idle cycles after slots 2 and 5.
    send_frame(8'h4D, 1'b1, 8'b0010_0100);
    cmp("gap_out_4d", 32'(dout[0]), 32'h4D);

    // Misplaced sync at slot 4 carrying 8'hFF.
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'(k == 0));
    send_frame(8'hFF, 1'b1, 8'h00);
    cmp("missync_out_ff", 32'(dout[0]), 32'hFF);

    // Missing sync after a good frame, then relock.
    send_frame(8'hA5, 1'b1, 8'h00);
    send_frame(8'h3C, 1'b0, 8'h00);
    cmp("nosync_strict_keep", 32'(dout[0]), 32'hA5);
    cmp("nosync_fly_commit", 32'(dout[1]), 32'h3C);
    send_frame(8'h96, 1'b1, 8'h00);
    cmp("relock_out_96", 32'(dout[0]), 32'h96);

    // Asynchronous reset between edges at slot 5.
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 1'(k == 0));
    #3 reset = 1'b1;
    #1 model_reset();
    check_all();
    cmp("async_out_rv", 32'(dout[0]), 32'(RESET_VAL));
    tick(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) tick(1'b1, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 8'h00);

    // Randomized traffic, mostly well-formed frames with occasional faults.
    for (int i = 0; i < 800; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_cnt[0] == 0) s = ($urandom_range(0, 7) != 0);
      else               s = ($urandom_range(0, 19) == 0);
      tick(1'($urandom_range(0, 1)), v, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
